// File: rtl/pipeline_stage_skid.sv
// Two-slot skid-buffered pipeline stage: registered outputs, In_Ready driven from state only.
// Define PIPELINE_STAGE_STATS_EN to add saturating Stall_Count / Flush_Count outputs.
module pipeline_stage_skid #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]    NOP_CTRL = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [1:0]        Occupancy
`ifdef PIPELINE_STAGE_STATS_EN
    ,
    output logic [15:0]       Stall_Count,
    output logic [15:0]       Flush_Count
`endif
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              accept;
    logic              deliver;

    assign In_Ready  = (state_q != StFull) && !Reset;
    assign Out_Valid = (state_q != StEmpty);
    assign Out_Data  = main_data_q;
    assign Out_Ctrl  = main_ctrl_q;
    assign accept    = In_Valid && In_Ready;
    assign deliver   = Out_Valid && Out_Ready;

    always_comb begin
        Occupancy = 2'd0;
        unique case (state_q)
            StOne:   Occupancy = 2'd1;
            StFull:  Occupancy = 2'd2;
            default: Occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (Flush) begin
            state_d     = StEmpty;
            main_data_d = '0;
            main_ctrl_d = NOP_CTRL;
            skid_data_d = '0;
            skid_ctrl_d = NOP_CTRL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StOne;
                        main_data_d = In_Data;
                        main_ctrl_d = In_Ctrl;
                    end
                end
                StOne: begin
                    if (accept && deliver) begin
                        main_data_d = In_Data;
                        main_ctrl_d = In_Ctrl;
                    end else if (accept) begin
                        state_d     = StFull;
                        skid_data_d = In_Data;
                        skid_ctrl_d = In_Ctrl;
                    end else if (deliver) begin
                        // An empty stage must present the NOP bundle, not stale data.
                        state_d     = StEmpty;
                        main_data_d = '0;
                        main_ctrl_d = NOP_CTRL;
                    end
                end
                StFull: begin
                    if (deliver) begin
                        state_d     = StOne;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = NOP_CTRL;
                    end
                end
                default: begin
                    state_d     = StEmpty;
                    main_data_d = '0;
                    main_ctrl_d = NOP_CTRL;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= NOP_CTRL;
            skid_data_q <= '0;
            skid_ctrl_q <= NOP_CTRL;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPELINE_STAGE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Out_Valid && !Out_Ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (Flush && ((Occupancy != 2'd0) || In_Valid) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: doc/pipeline_stage_skid.md
PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width (instruction/PC/data words, concatenated by the instantiator).
REQ-002 SHALL have parameter CTRL_W, default 16, controller-signal bundle width.
REQ-003 SHALL have parameter NOP_CTRL, default 0 (CTRL_W bits), control value presented for an empty or flushed stage.
REQ-004 SHALL have port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port In_Valid  in  1  upstream stage holds a valid entry.
REQ-007 SHALL have port In_Ready  out  1  stage can accept an entry this cycle.
REQ-008 SHALL have port In_Data  in  DATA_W  upstream payload.
REQ-009 SHALL have port In_Ctrl  in  CTRL_W  upstream control bundle.
REQ-010 SHALL have port Flush  in  1  synchronous discard of all held and incoming entries.
REQ-011 SHALL have port Out_Valid  out  1  downstream entry is valid.
REQ-012 SHALL have port Out_Ready  in  1  downstream accepts this cycle.
REQ-013 SHALL have port Out_Data  out  DATA_W  registered payload.
REQ-014 SHALL have port Out_Ctrl  out  CTRL_W  registered control bundle.
REQ-015 SHALL have port Occupancy  out  2  number of held entries (0, 1 or 2).

Function
REQ-016 Accept = In_Valid && In_Ready; Deliver = Out_Valid && Out_Ready.
REQ-017 Two storage slots: main (drives Out_*), skid (overflow); states EMPTY, ONE, FULL; Occupancy = 0/1/2 respectively.
REQ-018 In_Ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and 0 while Reset is asserted; it SHALL depend only on state (no combinational path from Out_Ready).
REQ-019 EMPTY: Accept -> ONE, main <= In_*; otherwise stay EMPTY.
REQ-020 ONE: Accept && Deliver -> ONE, main <= In_*; Accept && !Deliver -> FULL, skid <= In_*; !Accept && Deliver -> EMPTY; otherwise hold.
REQ-021 FULL: Deliver -> ONE, main <= skid; otherwise hold; no Accept is possible.
REQ-022 Out_Valid SHALL be 1 exactly in ONE and FULL; latency from Accept into EMPTY to Out_Valid is one cycle.
REQ-023 While Out_Valid && !Out_Ready, Out_Data and Out_Ctrl SHALL remain stable.
REQ-024 Entries SHALL be delivered in acceptance order, none duplicated or lost except by Flush.
REQ-025 Flush has priority over all transitions: next state EMPTY, both slots discarded, any same-cycle input dropped, main Out_Data <= 0, Out_Ctrl <= NOP_CTRL.
REQ-026 In EMPTY, Out_Data SHALL be 0 and Out_Ctrl SHALL be NOP_CTRL.
REQ-027 Width handling SHALL be bit-exact for any DATA_W >= 1 and CTRL_W >= 1; no truncation or sign extension.

Reset
REQ-028 On Reset assertion, asynchronously: state EMPTY, Out_Valid 0, Out_Data 0, Out_Ctrl NOP_CTRL, skid cleared, Occupancy 0, In_Ready 0.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries; first Accept possible on the first rising Clk edge after deassertion.

Configuration
REQ-030 Macro PIPELINE_STAGE_STATS_EN SHALL, when defined, add outputs Stall_Count (16) and Flush_Count (16), both reset to 0.
REQ-031 With PIPELINE_STAGE_STATS_EN: Stall_Count +1 each cycle Out_Valid && !Out_Ready; Flush_Count +1 each cycle Flush is asserted while Occupancy != 0 or In_Valid = 1; both saturate at 16'hFFFF.
REQ-032 Without PIPELINE_STAGE_STATS_EN: ports and counters absent; all other behaviour identical.

Verification
REQ-033 Reset then In_Valid=1, In_Data=32'h0000_1234, Out_Ready=1 -> next cycle Out_Valid=1, Out_Data=32'h0000_1234, Occupancy=1.
REQ-034 Out_Ready=0, push 32'hA, 32'hB -> Occupancy=2, In_Ready=0, Out_Data=32'hA stable; Out_Ready=1 -> 32'hA then 32'hB delivered in consecutive cycles.
REQ-035 Occupancy=2 with Flush=1 and In_Valid=1 -> next cycle Occupancy=0, Out_Valid=0, Out_Ctrl=NOP_CTRL, Out_Data=0; input entry never appears.
REQ-036 Continuous In_Valid=1, Out_Ready=1 over 100 incrementing words -> 100 words out, in order, one per cycle, Occupancy never 2.
REQ-037 Reset pulsed between Clk edges while Occupancy=2 -> outputs cleared immediately without a Clk edge; In_Ready=0 until deassertion.
REQ-038 With PIPELINE_STAGE_STATS_EN, Out_Valid=1, Out_Ready=0 held 70000 cycles -> Stall_Count=16'hFFFF; one non-empty Flush -> Flush_Count=1.
